// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter that shares one combinational ALU between two
//   requesters. The FSM runs IDLE -> EXEC -> RESP. In IDLE it grants one
//   valid requester and latches its operands. In EXEC the latched operands
//   drive the external ALU. At the EXEC->RESP edge the ALU outputs are
//   registered, and they are held in RESP until the consumer takes them.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   reqX_valid / reqX_ready           request handshake for requester X (0/1)
//   reqX_a, reqX_b, reqX_aop, reqX_cin operands, opcode and carry-in
//   alu_a, alu_b, alu_aop, alu_cin    latched operands to the shared ALU
//   alu_result, alu_zero/ovf/cout     combinational ALU outputs
//   rsp_valid / rsp_ready             response handshake
//   rsp_id, rsp_data, rsp_zero/ovf/cout registered response
//   busy                              high whenever the FSM is not in IDLE
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_aop,
    input  logic         req0_cin,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_aop,
    input  logic         req1_cin,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_aop,
    output logic         alu_cin,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_ovf,
    input  logic         alu_cout,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_ovf,
    output logic         rsp_cout,

    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic   last_grant;   // requester granted most recently
    logic   lat_id;       // requester owning the in-flight operation
    logic   grant_id;
    logic   accept;

    // Grant selection: on a tie the requester not granted last wins.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is gated by rst so nothing handshakes while reset is held.
    assign accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch and grant pointer; both change only on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_aop    <= '0;
            alu_cin    <= 1'b0;
            lat_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_a      <= grant_id ? req1_a   : req0_a;
            alu_b      <= grant_id ? req1_b   : req0_b;
            alu_aop    <= grant_id ? req1_aop : req0_aop;
            alu_cin    <= grant_id ? req1_cin : req0_cin;
            lat_id     <= grant_id;
            last_grant <= grant_id;
        end
    end

    // Response capture at the EXEC->RESP edge; held untouched through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_cout <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id   <= lat_id;
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_ovf  <= alu_ovf;
            rsp_cout <= alu_cout;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter (N=8). Directed operations are queued per
// requester; accepted operations push their hand-computed response into a
// scoreboard that a separate monitor drains as responses are consumed.
module tb_alu_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   rv;
    logic [1:0]   rr;
    logic [N-1:0] ra [2];
    logic [N-1:0] rb [2];
    logic [2:0]   raop [2];
    logic [1:0]   rcin;

    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_aop;
    logic         alu_cin, alu_zero, alu_ovf, alu_cout;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf, rsp_cout, busy;
    logic [N-1:0] rsp_data;

    alu_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (rv[0]),
        .req0_ready (rr[0]),
        .req0_a     (ra[0]),
        .req0_b     (rb[0]),
        .req0_aop   (raop[0]),
        .req0_cin   (rcin[0]),
        .req1_valid (rv[1]),
        .req1_ready (rr[1]),
        .req1_a     (ra[1]),
        .req1_b     (rb[1]),
        .req1_aop   (raop[1]),
        .req1_cin   (rcin[1]),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_aop    (alu_aop),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: 110 add, 101 subtract (borrow in/out), 000 and,
    // 001 or, 010 xor, 011 pass a, anything else pass b.
    logic [N:0] s;
    always_comb begin
        s          = '0;
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_cout   = 1'b0;
        case (alu_aop)
            3'b110: begin
                s          = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
                alu_result = s[N-1:0];
                alu_cout   = s[N];
                alu_ovf    = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
            end
            3'b101: begin
                s          = {1'b0, alu_a} - {1'b0, alu_b} - {{N{1'b0}}, alu_cin};
                alu_result = s[N-1:0];
                alu_cout   = s[N];
                alu_ovf    = (alu_a[N-1] != alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
            end
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a ^ alu_b;
            3'b011:  alu_result = alu_a;
            default: alu_result = alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic [N-1:0] a, b;
        logic [2:0]   aop;
        logic         cin;
        logic [N-1:0] d;
        logic         z, o, c;
    } op_t;

    typedef struct {
        logic         id;
        logic [N-1:0] d;
        logic         z, o, c;
        int           acc;
    } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t exp_q[$];
    int   gq[$];       // expected grant order (requester ids)

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    function automatic op_t mk(logic [N-1:0] a, logic [N-1:0] b, logic [2:0] aop,
                               logic cin, logic [N-1:0] d, logic z, logic o, logic c);
        op_t r;
        r.a = a; r.b = b; r.aop = aop; r.cin = cin;
        r.d = d; r.z = z; r.o = o; r.c = c;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_exp(logic id, op_t op);
        exp_t e;
        e.id = id; e.d = op.d; e.z = op.z; e.o = op.o; e.c = op.c;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        if (gq.size() > 0) begin
            chk("grant_order", {31'd0, id}, gq[0]);
            void'(gq.pop_front());
        end
    endtask

    // Requester drivers: present queue heads after each rising edge, note
    // handshakes mid-cycle (acceptance happens at the following edge).
    initial begin
        rv   = '0;
        rcin = '0;
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0; rb[i] = '0; raop[i] = '0;
        end
        forever begin
            @(posedge clk); #1;
            rv[0] = (q0.size() > 0);
            if (rv[0]) begin
                ra[0] = q0[0].a; rb[0] = q0[0].b; raop[0] = q0[0].aop; rcin[0] = q0[0].cin;
            end
            rv[1] = (q1.size() > 0);
            if (rv[1]) begin
                ra[1] = q1[0].a; rb[1] = q1[0].b; raop[1] = q1[0].aop; rcin[1] = q1[0].cin;
            end
            @(negedge clk); #1;
            if (rv[0] && rr[0]) begin
                push_exp(1'b0, q0[0]);
                void'(q0.pop_front());
            end
            if (rv[1] && rr[1]) begin
                push_exp(1'b1, q1[0]);
                void'(q1.pop_front());
            end
        end
    end

    // Monitor: latency, stability under backpressure, no grants while busy,
    // and scoreboard comparison on every consumed response.
    logic         pv = 1'b0, prr = 1'b0, sid = 1'b0, sz = 1'b0, so = 1'b0, sc = 1'b0;
    logic [N-1:0] sd = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (busy) chk("ready_while_busy", {30'd0, rr}, 32'd0);
            if (rsp_valid) chk("busy_in_resp", {31'd0, busy}, 32'd1);
            if (rsp_valid && !pv) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                else chk("latency", cyc - exp_q[0].acc, 32'd1);
            end
            if (rsp_valid && pv && !prr) begin
                chk("stable_data", {24'd0, rsp_data}, {24'd0, sd});
                chk("stable_flags", {28'd0, rsp_id, rsp_zero, rsp_ovf, rsp_cout},
                    {28'd0, sid, sz, so, sc});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_without_request", 32'd1, 32'd0);
                end else begin
                    chk("rsp_id",   {31'd0, rsp_id},   {31'd0, exp_q[0].id});
                    chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q[0].d});
                    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, exp_q[0].z});
                    chk("rsp_ovf",  {31'd0, rsp_ovf},  {31'd0, exp_q[0].o});
                    chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, exp_q[0].c});
                    void'(exp_q.pop_front());
                end
            end
            pv = rsp_valid; prr = rsp_ready;
            sd = rsp_data; sid = rsp_id; sz = rsp_zero; so = rsp_ovf; sc = rsp_cout;
        end
    end

    task automatic wait_drain(int max_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #3;
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_cleared(string tag);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
        chk({tag, "_ready"},     {30'd0, rr}, 32'd0);
        chk({tag, "_alu_ops"},   {alu_cin, alu_aop, alu_a, alu_b}, 32'd0);
        chk({tag, "_rsp_regs"},  {rsp_id, rsp_zero, rsp_ovf, rsp_cout, rsp_data}, 32'd0);
    endtask

    initial begin
        rsp_ready = 1'b1;

        // Reset state, with req0 already valid; first edge after release accepts.
        q0.push_back(mk(8'd5, 8'd7, 3'b110, 1'b0, 8'd12, 1'b0, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        #3 check_cleared("reset");
        @(negedge clk); rst = 1'b0;
        wait_drain(20);

        // Tie from reset: grants 0,1,0,1.
        @(negedge clk); rst = 1'b1;
        q0.push_back(mk(8'd1,   8'd2, 3'b110, 1'b1, 8'd4,   1'b0, 1'b0, 1'b0));
        q0.push_back(mk(8'd127, 8'd1, 3'b110, 1'b0, 8'h80,  1'b0, 1'b1, 1'b0));
        q1.push_back(mk(8'd9,   8'd9, 3'b101, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0));
        q1.push_back(mk(8'd255, 8'd1, 3'b110, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1));
        gq = '{0, 1, 0, 1};
        @(negedge clk); rst = 1'b0;
        wait_drain(40);

        // Mixed opcodes, alternating requesters.
        q0.push_back(mk(8'd3,   8'd5,   3'b101, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1));
        q0.push_back(mk(8'hF0,  8'h3C,  3'b000, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0));
        q0.push_back(mk(8'hAA,  8'hAA,  3'b010, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        q1.push_back(mk(8'h80,  8'h01,  3'b101, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0));
        q1.push_back(mk(8'h0F,  8'h30,  3'b001, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0));
        q1.push_back(mk(8'h5A,  8'h11,  3'b011, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0));
        gq = '{0, 1, 0, 1, 0, 1};
        wait_drain(60);

        // Single requester repeatedly granted.
        q1.push_back(mk(8'h12,  8'h55,  3'b111, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0));
        q1.push_back(mk(8'd10,  8'd3,   3'b101, 1'b1, 8'd6,  1'b0, 1'b0, 1'b0));
        gq = '{1, 1};
        wait_drain(30);

        // Backpressure: response held for many cycles with both requesters waiting.
        @(posedge clk); #1 rsp_ready = 1'b0;
        q0.push_back(mk(8'd200, 8'd100, 3'b110, 1'b1, 8'h2D, 1'b0, 1'b0, 1'b1));
        q1.push_back(mk(8'h77,  8'h00,  3'b100, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        gq = '{0, 1};
        repeat (12) @(negedge clk);
        #3;
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_busy",      {31'd0, busy}, 32'd1);
        chk("bp_ready",     {30'd0, rr}, 32'd0);
        chk("bp_rsp_data",  {24'd0, rsp_data}, 32'h2D);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain(30);

        // Reset during EXEC: in-flight op discarded, pointer back to requester 1.
        q0.push_back(mk(8'd1, 8'd1, 3'b110, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0));
        gq = '{0};
        begin : find_exec
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk); #2;
                if (busy && !rsp_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("reach_exec", {31'd0, seen}, 32'd1);
        end
        rst = 1'b1;
        exp_q.delete();
        #1 check_cleared("mid_exec_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q0.push_back(mk(8'd20, 8'd22, 3'b110, 1'b0, 8'd42, 1'b0, 1'b0, 1'b0));
        q1.push_back(mk(8'd50, 8'd8,  3'b101, 1'b0, 8'd42, 1'b0, 1'b0, 1'b0));
        gq = '{0, 1};
        wait_drain(40);

        chk("grant_queue_empty", gq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
